// File: rtl/score_cell_engine.sv
// Needleman-Wunsch style cell filler: walks an (N+1)x(N+1) score matrix row by
// row, reads the diag/up/left neighbours from an external RAM, then emits one
// scored cell (max + traceback dir) per 5-cycle slot to a downstream writer.
module score_cell_engine #(
  parameter int N        = 5,
  parameter int MATCH    = 1,
  parameter int MISMATCH = -1,
  parameter int GAP      = -2,
  localparam int BitAddr = $clog2(N),
  localparam int ADDR_W  = $clog2((N+1)*(N+1))
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [1:0]              seq_a_char,
  input  logic [1:0]              seq_b_char,
  output logic                    rd_en,
  output logic [ADDR_W-1:0]       rd_addr,
  input  logic signed [8:0]       rd_data,
  output logic [BitAddr:0]        i,
  output logic [BitAddr:0]        j,
  output logic signed [8:0]       max,
  output logic [1:0]              dir,
  output logic                    en_ins,
  output logic                    busy,
  output logic                    done
);

  typedef enum logic [2:0] {
    IDLE, RD_DIAG, RD_UP, RD_LEFT, CALC, WRITE, DONE
  } state_t;

  localparam logic [BitAddr:0]   ONE    = (BitAddr+1)'(1);
  localparam logic [BitAddr:0]   IDX_N  = (BitAddr+1)'(N);
  localparam logic signed [9:0]  S_MAT  = 10'(MATCH);
  localparam logic signed [9:0]  S_MIS  = 10'(MISMATCH);
  localparam logic signed [9:0]  S_GAP  = 10'(GAP);
  localparam logic signed [9:0]  SAT_HI = 10'sd255;
  localparam logic signed [9:0]  SAT_LO = -10'sd256;

  state_t state;

  // neighbour scores captured while the next read is in flight
  logic signed [8:0] diag_q, up_q;

  logic signed [9:0] c_diag, c_up, c_left, best;
  logic [1:0]        best_dir;
  logic signed [8:0] best_sat;

  logic              last_col, last_row;
  logic [BitAddr:0]  nxt_i, nxt_j;

  // row-major flat address of matrix cell (r,c)
  function automatic logic [ADDR_W-1:0] cell_addr(input logic [BitAddr:0] r,
                                                  input logic [BitAddr:0] c);
    return ADDR_W'(int'(r) * (N+1) + int'(c));
  endfunction

  // Candidate scores at 10 bits so the +/- step never wraps before saturation;
  // left arrives on rd_data during CALC and is used directly.
  always_comb begin
    c_diag = 10'(diag_q) + ((seq_a_char == seq_b_char) ? S_MAT : S_MIS);
    c_up   = 10'(up_q) + S_GAP;
    c_left = 10'(rd_data) + S_GAP;
    // diag wins ties over up, up wins ties over left
    if (c_diag >= c_up && c_diag >= c_left) begin
      best     = c_diag;
      best_dir = 2'b00;
    end else if (c_up >= c_left) begin
      best     = c_up;
      best_dir = 2'b01;
    end else begin
      best     = c_left;
      best_dir = 2'b10;
    end
    if (best > SAT_HI)      best_sat = 9'sd255;
    else if (best < SAT_LO) best_sat = -9'sd256;
    else                    best_sat = best[8:0];
  end

  // Raster-order advance: next column, or wrap to column 1 of the next row.
  always_comb begin
    last_col = (j == IDX_N);
    last_row = (i == IDX_N);
    nxt_i    = last_col ? i + ONE : i;
    nxt_j    = last_col ? ONE : j + ONE;
  end

  // Cell sequencer; all outputs are registered and set on entry to the state
  // that owns them, so rd_en/rd_addr are valid throughout each RD_* state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      i       <= '0;
      j       <= '0;
      max     <= '0;
      dir     <= 2'b00;
      rd_en   <= 1'b0;
      rd_addr <= '0;
      en_ins  <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      diag_q  <= '0;
      up_q    <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state   <= RD_DIAG;
            i       <= ONE;
            j       <= ONE;
            rd_en   <= 1'b1;
            rd_addr <= cell_addr('0, '0);
            busy    <= 1'b1;
            done    <= 1'b0;
          end
        end
        RD_DIAG: begin
          state   <= RD_UP;
          rd_addr <= cell_addr(i - ONE, j);
        end
        RD_UP: begin
          diag_q  <= rd_data;
          state   <= RD_LEFT;
          rd_addr <= cell_addr(i, j - ONE);
        end
        RD_LEFT: begin
          up_q  <= rd_data;
          rd_en <= 1'b0;
          state <= CALC;
        end
        CALC: begin
          max    <= best_sat;
          dir    <= best_dir;
          en_ins <= 1'b1;
          state  <= WRITE;
        end
        WRITE: begin
          en_ins <= 1'b0;
          if (last_col && last_row) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else begin
            i       <= nxt_i;
            j       <= nxt_j;
            rd_en   <= 1'b1;
            rd_addr <= cell_addr(nxt_i - ONE, nxt_j - ONE);
            state   <= RD_DIAG;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/score_cell_engine.md
SCORE_CELL_ENGINE -- requirements
Module: score_cell_engine

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
- N, 5, sequence length; the matrix is (N+1)x(N+1) and row 0 / column 0 are pre-initialised.
- MATCH, 1, signed score added on a character match.
- MISMATCH, -1, signed score added on a character mismatch.
- GAP, -2, signed score added for an up or left move.
- Derived: BitAddr = $clog2(N); ADDR_W = $clog2((N+1)*(N+1)).

REQ-002 Ports SHALL be, one per line: name, direction, width, meaning.
- clk, in, 1, single clock, rising edge.
- rst, in, 1, asynchronous, active-high reset.
- start, in, 1, one-cycle request to fill the matrix.
- seq_a_char, in, 2, nucleotide A[i-1] for the current i (A=00, C=01, G=10, T=11).
- seq_b_char, in, 2, nucleotide B[j-1] for the current j.
- rd_en, out, 1, score RAM read strobe.
- rd_addr, out, ADDR_W, score RAM read address, row*(N+1)+col.
- rd_data, in, 9, signed score; valid exactly 1 cycle after rd_en.
- i, out, BitAddr+1, current row; feeds the downstream score writer and the sequence-A lookup.
- j, out, BitAddr+1, current column; feeds the downstream score writer and the sequence-B lookup.
- max, out, 9, signed cell score for the downstream writer.
- dir, out, 2, traceback direction: 00 diag, 01 up, 10 left.
- en_ins, out, 1, one-cycle write strobe qualifying i, j, max and dir.
- busy, out, 1, high from the cycle after start is accepted until DONE.
- done, out, 1, high in DONE; held until the next accepted start.

Function
REQ-003 The state machine SHALL have states IDLE, RD_DIAG, RD_UP, RD_LEFT, CALC, WRITE and DONE.
REQ-004 IDLE or DONE with start=1 SHALL move to RD_DIAG with i=1 and j=1, and clear done.
REQ-005 start SHALL be ignored in every other state.
REQ-006 RD_DIAG SHALL drive rd_en=1 and rd_addr=(i-1)*(N+1)+(j-1).
REQ-007 RD_UP SHALL drive rd_en=1 and rd_addr=(i-1)*(N+1)+j, and capture rd_data as the diag value.
REQ-008 RD_LEFT SHALL drive rd_en=1 and rd_addr=i*(N+1)+(j-1), and capture rd_data as the up value.
REQ-009 CALC SHALL capture rd_data as the left value, sample seq_a_char and seq_b_char, and register max and dir.
REQ-010 rd_en SHALL be 0 in IDLE, CALC, WRITE and DONE.
REQ-011 Candidate scores SHALL be computed at 10-bit signed precision:
- diag + (MATCH if the characters are equal, else MISMATCH);
- up + GAP;
- left + GAP.
REQ-012 max SHALL be the largest candidate, saturated to the range [-256, +255].
REQ-013 On ties the priority SHALL be diag > up > left; dir reports the winner.
REQ-014 WRITE SHALL assert en_ins for exactly 1 cycle with i, j, max and dir stable.
REQ-015 After WRITE, if j<N: j increments and the state goes to RD_DIAG.
REQ-016 After WRITE, if j=N and i<N: j=1, i increments and the state goes to RD_DIAG.
REQ-017 After WRITE at (N,N), the state SHALL go to DONE.
REQ-018 Each cell SHALL take 5 cycles; done SHALL rise exactly 5*N*N cycles after the start-sampling edge.
REQ-019 A cell's own write SHALL precede every read of that cell's address; this is guaranteed by the 5-cycle cadence and needs no bypass.
REQ-020 i, j, max and dir SHALL hold their values outside WRITE.

Reset
REQ-021 rst=1 SHALL asynchronously force:
- state=IDLE;
- i=0 and j=0;
- max=0 and dir=00;
- rd_en=0, rd_addr=0, en_ins=0, busy=0, done=0.
REQ-022 rst asserted mid-fill SHALL abort the fill with no further en_ins pulse.
REQ-023 After rst deasserts, the block SHALL wait in IDLE for a new start.

Verification
REQ-024 Basic fill, N=2, A="AC", B="AC", RAM pre-loaded with row 0 and column 0 = 0, -2, -4; then start.
- Required en_ins sequence: (1,1) max=1 dir=00; (1,2) max=-1 dir=10; (2,1) max=-1 dir=01; (2,2) max=2 dir=00.
- done rises 20 cycles after start.
REQ-025 Tie, single cell: diag=-1 with a mismatch (candidate -2), up=0 (candidate -2), left=-4.
- Required: max=-2, dir=00.
REQ-026 Saturation: rd_data=-256 for every read, all mismatches.
- Required: max=-256 and dir=00 on every cell, with no wrap to positive.
REQ-027 start pulsed while busy=1, then after done=1.
- Required: the first pulse is ignored; the second restarts at (1,1) and clears done.
REQ-028 rst pulsed during RD_UP of cell (1,2).
- Required: all outputs take their REQ-021 values immediately; no en_ins until a new start.
REQ-029 Read timing: check rd_addr sequence 0, 1, 3 for cell (1,1) with N=2; rd_en is high on exactly 3 cycles per cell.
